hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 146 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register result scoreboard for an in-order RISC-V pipeline.
// Tracks load/mul countdowns and one outstanding divide; drives stall/flush controls.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 3,
    parameter int CNT_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs2,
    input  logic [$clog2(NUM_REGS)-1:0] id_rd,
    input  logic [6:0]                  opcode,
    input  logic                        id_valid,
    input  logic                        id_rd_wr,
    input  logic [1:0]                  id_class,
    input  logic                        div_done,
    input  logic [$clog2(NUM_REGS)-1:0] div_rd,
    input  logic                        jump_branch_taken,
    input  logic                        invalid_inst,
    input  logic                        stall,
    output logic                        if_id_pipeline_flush,
    output logic                        if_id_pipeline_en,
    output logic                        id_ex_pipeline_flush,
    output logic                        id_ex_pipeline_en,
    output logic                        pc_en,
    output logic                        ex_mem_pipeline_en,
    output logic                        hazard_stall,
    output logic                        div_busy
);

    localparam int RW = $clog2(NUM_REGS);

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LOAD = 2'b01;
    localparam logic [1:0] CLS_MUL  = 2'b10;
    localparam logic [1:0] CLS_DIV  = 2'b11;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] divpend_q;
    logic [NUM_REGS-1:0] divpend_d;
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] done_mask;
    logic                use_rs1;
    logic                use_rs2;
    logic                div_busy_eff;
    logic                issue;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        unique case (opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // A divide completing this cycle releases its register immediately.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            done_mask[r] = div_done && (div_rd == RW'(r));
            pend[r]      = (cnt_q[r] != '0) || (divpend_q[r] && !done_mask[r]);
        end
        pend[0] = 1'b0;
    end

    assign div_busy_eff = |(divpend_q & ~done_mask);
    assign div_busy     = |divpend_q;

    assign hazard_stall = id_valid && (
        (use_rs1 && pend[id_rs1]) ||
        (use_rs2 && pend[id_rs2]) ||
        (id_rd_wr && pend[id_rd]) ||
        ((id_class == CLS_DIV) && div_busy_eff));

    always_comb begin
        if_id_pipeline_flush = 1'b0;
        if_id_pipeline_en    = 1'b1;
        id_ex_pipeline_flush = 1'b0;
        id_ex_pipeline_en    = 1'b1;
        pc_en                = 1'b1;
        ex_mem_pipeline_en   = 1'b1;
        if (jump_branch_taken) begin
            if_id_pipeline_flush = 1'b1;
            id_ex_pipeline_flush = 1'b1;
            ex_mem_pipeline_en   = 1'b0;
        end else if (hazard_stall) begin
            if_id_pipeline_en    = 1'b0;
            pc_en                = 1'b0;
            id_ex_pipeline_flush = 1'b1;
        end else if (stall) begin
            if_id_pipeline_en = 1'b0;
            id_ex_pipeline_en = 1'b0;
            pc_en             = 1'b0;
        end else if (invalid_inst) begin
            id_ex_pipeline_flush = 1'b1;
        end
    end

    assign issue = id_valid && id_rd_wr && (id_rd != '0) &&
                   !jump_branch_taken && !hazard_stall &&
                   !stall && !invalid_inst;

    // Issue overrides both the countdown and a same-cycle divide clear.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!stall && (cnt_q[r] != '0))
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            divpend_d[r] = divpend_q[r] && !done_mask[r];
            if (issue && (id_rd == RW'(r))) begin
                unique case (id_class)
                    CLS_LOAD: cnt_d[r] = CNT_W'(LOAD_LAT);
                    CLS_MUL:  cnt_d[r] = CNT_W'(MUL_LAT);
                    CLS_ALU:  cnt_d[r] = '0;
                    CLS_DIV: begin
                        cnt_d[r]     = '0;
                        divpend_d[r] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        cnt_d[0]     = '0;
        divpend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= '0;
            divpend_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= cnt_d[r];
            divpend_q <= divpend_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters.
// Each task drives one scenario and checks outputs against hand-computed values.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, id_rd, div_rd;
    logic [6:0] opcode;
    logic       id_valid, id_rd_wr, div_done;
    logic [1:0] id_class;
    logic       jump_branch_taken, invalid_inst, stall;
    logic       if_id_pipeline_flush, if_id_pipeline_en;
    logic       id_ex_pipeline_flush, id_ex_pipeline_en;
    logic       pc_en, ex_mem_pipeline_en, hazard_stall, div_busy;
    logic [5:0] pipe;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [1:0] ALU = 2'b00, LD = 2'b01, MUL = 2'b10, DIV = 2'b11;

    // {if_id_flush, if_id_en, id_ex_flush, id_ex_en, pc_en, ex_mem_en}
    localparam logic [5:0] P_DEF = 6'b010111;
    localparam logic [5:0] P_HAZ = 6'b001101;
    localparam logic [5:0] P_STL = 6'b000001;
    localparam logic [5:0] P_INV = 6'b011111;
    localparam logic [5:0] P_JMP = 6'b111110;

    assign pipe = {if_id_pipeline_flush, if_id_pipeline_en, id_ex_pipeline_flush,
                   id_ex_pipeline_en, pc_en, ex_mem_pipeline_en};

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .opcode(opcode),
        .id_valid(id_valid), .id_rd_wr(id_rd_wr), .id_class(id_class),
        .div_done(div_done), .div_rd(div_rd),
        .jump_branch_taken(jump_branch_taken), .invalid_inst(invalid_inst),
        .stall(stall),
        .if_id_pipeline_flush(if_id_pipeline_flush),
        .if_id_pipeline_en(if_id_pipeline_en),
        .id_ex_pipeline_flush(id_ex_pipeline_flush),
        .id_ex_pipeline_en(id_ex_pipeline_en),
        .pc_en(pc_en), .ex_mem_pipeline_en(ex_mem_pipeline_en),
        .hazard_stall(hazard_stall), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic wr,
                          input logic [1:0] cls);
        id_valid = v; opcode = op; id_rs1 = r1; id_rs2 = r2;
        id_rd = rd; id_rd_wr = wr; id_class = cls;
        #1;
    endtask

    task automatic idle;
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, ALU);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; div_done = 1'b0; div_rd = '0;
        jump_branch_taken = 1'b0; invalid_inst = 1'b0; stall = 1'b0;
        idle();
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL rst_hs: got %b want 0", hazard_stall); end
        n_chk++; if (div_busy !== 1'b0) begin n_fail++; $display("FAIL rst_db: got %b want 0", div_busy); end
        n_chk++; if (pipe !== P_DEF) begin n_fail++; $display("FAIL rst_pipe: got %b want %b", pipe, P_DEF); end
        jump_branch_taken = 1'b1; #1;
        n_chk++; if (pipe !== P_JMP) begin n_fail++; $display("FAIL rst_jmp: got %b want %b", pipe, P_JMP); end
        jump_branch_taken = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use;
        set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, LD);
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_issue: got %b want 0", hazard_stall); end
        tick();
        set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b1, ALU);
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", hazard_stall); end
        n_chk++; if (pipe !== P_HAZ) begin n_fail++; $display("FAIL lu_pipe: got %b want %b", pipe, P_HAZ); end
        tick();
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", hazard_stall); end
        n_chk++; if (pipe !== P_DEF) begin n_fail++; $display("FAIL lu_pipe2: got %b want %b", pipe, P_DEF); end
        tick();
        idle(); tick();
    endtask

    task automatic test_mul;
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd7, 1'b1, MUL);
        tick();
        set_id(1'b1, OP_R, 5'd3, 5'd7, 5'd10, 1'b1, ALU);
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL mul_t1: got %b want 1", hazard_stall); end
        tick();
        stall = 1'b1; #1;
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL mul_t2: got %b want 1", hazard_stall); end
        n_chk++; if (pipe !== P_HAZ) begin n_fail++; $display("FAIL mul_prio: got %b want %b", pipe, P_HAZ); end
        tick();
        stall = 1'b0; #1;
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL mul_t3: got %b want 1", hazard_stall); end
        tick();
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL mul_t4_frozen: got %b want 1", hazard_stall); end
        tick();
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL mul_t5: got %b want 0", hazard_stall); end
        n_chk++; if (pipe !== P_DEF) begin n_fail++; $display("FAIL mul_pipe5: got %b want %b", pipe, P_DEF); end
        tick();
        idle(); tick();
    endtask

    task automatic test_div;
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd8, 1'b1, DIV);
        n_chk++; if (div_busy !== 1'b0) begin n_fail++; $display("FAIL div_idle: got %b want 0", div_busy); end
        tick();
        set_id(1'b1, OP_R, 5'd3, 5'd4, 5'd9, 1'b1, DIV);
        n_chk++; if (div_busy !== 1'b1) begin n_fail++; $display("FAIL div_busy1: got %b want 1", div_busy); end
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL div_struct: got %b want 1", hazard_stall); end
        tick();
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL div_struct2: got %b want 1", hazard_stall); end
        div_done = 1'b1; div_rd = 5'd8; #1;
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL div_done_mask: got %b want 0", hazard_stall); end
        n_chk++; if (pipe !== P_DEF) begin n_fail++; $display("FAIL div_done_pipe: got %b want %b", pipe, P_DEF); end
        tick();
        div_done = 1'b0;
        set_id(1'b1, OP_R, 5'd9, 5'd0, 5'd11, 1'b1, ALU);
        n_chk++; if (div_busy !== 1'b1) begin n_fail++; $display("FAIL div_busy2: got %b want 1", div_busy); end
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL div_raw: got %b want 1", hazard_stall); end
        div_done = 1'b1; div_rd = 5'd9; #1;
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL div_raw_mask: got %b want 0", hazard_stall); end
        tick();
        div_done = 1'b0;
        idle();
        n_chk++; if (div_busy !== 1'b0) begin n_fail++; $display("FAIL div_clear: got %b want 0", div_busy); end
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd12, 1'b1, DIV);
        div_done = 1'b1; div_rd = 5'd12; #1;
        tick();
        div_done = 1'b0;
        idle();
        n_chk++; if (div_busy !== 1'b1) begin n_fail++; $display("FAIL div_set_wins: got %b want 1", div_busy); end
        div_done = 1'b1; div_rd = 5'd12;
        tick();
        div_done = 1'b0; #1;
        n_chk++; if (div_busy !== 1'b0) begin n_fail++; $display("FAIL div_clear2: got %b want 0", div_busy); end
        tick();
    endtask

    task automatic test_jump;
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd7, 1'b1, MUL);
        tick();
        set_id(1'b1, OP_R, 5'd7, 5'd1, 5'd10, 1'b1, ALU);
        jump_branch_taken = 1'b1; #1;
        n_chk++; if (pipe !== P_JMP) begin n_fail++; $display("FAIL jmp_pipe: got %b want %b", pipe, P_JMP); end
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL jmp_hs: got %b want 1", hazard_stall); end
        tick();
        jump_branch_taken = 1'b0; #1;
        n_chk++; if (pipe !== P_HAZ) begin n_fail++; $display("FAIL jmp_keep: got %b want %b", pipe, P_HAZ); end
        tick();
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL jmp_keep2: got %b want 1", hazard_stall); end
        tick();
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL jmp_release: got %b want 0", hazard_stall); end
        tick();
        idle(); tick();
    endtask

    task automatic test_invalid_and_stall;
        set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd13, 1'b1, LD);
        invalid_inst = 1'b1; #1;
        n_chk++; if (pipe !== P_INV) begin n_fail++; $display("FAIL inv_pipe: got %b want %b", pipe, P_INV); end
        tick();
        invalid_inst = 1'b0;
        set_id(1'b1, OP_R, 5'd13, 5'd1, 5'd14, 1'b1, ALU);
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL inv_noissue: got %b want 0", hazard_stall); end
        tick();
        set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd15, 1'b1, LD);
        stall = 1'b1; #1;
        n_chk++; if (pipe !== P_STL) begin n_fail++; $display("FAIL stl_pipe: got %b want %b", pipe, P_STL); end
        invalid_inst = 1'b1; #1;
        n_chk++; if (pipe !== P_STL) begin n_fail++; $display("FAIL stl_over_inv: got %b want %b", pipe, P_STL); end
        tick();
        stall = 1'b0; invalid_inst = 1'b0;
        set_id(1'b1, OP_R, 5'd15, 5'd1, 5'd16, 1'b1, ALU);
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL stl_noissue: got %b want 0", hazard_stall); end
        tick();
        idle(); tick();
    endtask

    task automatic test_decode_waw;
        set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, LD);
        tick();
        set_id(1'b1, OP_I, 5'd1, 5'd5, 5'd16, 1'b1, ALU);
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL dec_imm_rs2: got %b want 0", hazard_stall); end
        set_id(1'b1, OP_LUI, 5'd5, 5'd5, 5'd17, 1'b1, ALU);
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL dec_lui: got %b want 0", hazard_stall); end
        set_id(1'b1, OP_ST, 5'd1, 5'd5, 5'd0, 1'b0, ALU);
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL dec_store_rs2: got %b want 1", hazard_stall); end
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5, 1'b1, ALU);
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL waw: got %b want 1", hazard_stall); end
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5, 1'b0, ALU);
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL waw_nowr: got %b want 0", hazard_stall); end
        set_id(1'b0, OP_R, 5'd5, 5'd5, 5'd5, 1'b1, ALU);
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL novalid: got %b want 0", hazard_stall); end
        tick();
        idle(); tick();
    endtask

    task automatic test_x0;
        set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd0, 1'b1, LD);
        tick();
        set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd1, 1'b1, ALU);
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL x0_use: got %b want 0", hazard_stall); end
        tick();
        idle(); tick();
    endtask

    task automatic test_reset_mid;
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd7, 1'b1, MUL);
        tick();
        set_id(1'b1, OP_R, 5'd7, 5'd7, 5'd18, 1'b1, ALU);
        n_chk++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got %b want 1", hazard_stall); end
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL rm_async: got %b want 0", hazard_stall); end
        n_chk++; if (pipe !== P_DEF) begin n_fail++; $display("FAIL rm_pipe: got %b want %b", pipe, P_DEF); end
        tick();
        rst_n = 1'b1; #1;
        n_chk++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL rm_after: got %b want 0", hazard_stall); end
        n_chk++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL rm_pc_en: got %b want 1", pc_en); end
        tick();
        idle(); tick();
    endtask

    initial begin
        #2;
        test_reset();
        test_load_use();
        test_mul();
        test_div();
        test_jump();
        test_invalid_and_stall();
        test_decode_waw();
        test_x0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
